// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcode, instruction-field and FSM definitions for the ALU issue controller.
// Also holds the operand-B selection and opcode-mapping helpers.
package alu_issue_ctrl_pkg;

  localparam int DATA_W  = 16;
  localparam int INSTR_W = 10;
  localparam int NREG    = 4;
  localparam int REG_AW  = 2;
  localparam int CNT_W   = 4;

  localparam int OPC_MSB  = 9;
  localparam int OPC_LSB  = 7;
  localparam int RA_MSB   = 6;
  localparam int RA_LSB   = 5;
  localparam int RB_MSB   = 4;
  localparam int RB_LSB   = 3;
  localparam int IMM3_MSB = 2;
  localparam int IMM5_MSB = 4;

  typedef enum logic [2:0] {
    OPC_ADD   = 3'd0,
    OPC_SUB   = 3'd1,
    OPC_PAR   = 3'd2,
    OPC_XOR   = 3'd3,
    OPC_SPLIT = 3'd4,
    OPC_MOD2  = 3'd5,
    OPC_PASS  = 3'd6,
    OPC_LDI   = 3'd7
  } opc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // LDI has no ALU opcode of its own; it pushes the immediate through PASS.
  function automatic logic [2:0] map_alu_op(input logic [2:0] opc);
    logic [2:0] op;
    if (opc == OPC_LDI) begin
      op = OPC_PASS;
    end else begin
      op = opc;
    end
    return op;
  endfunction

  function automatic logic [DATA_W-1:0] sel_operand_b(input logic [2:0]         opc,
                                                      input logic [DATA_W-1:0]  rb_data,
                                                      input logic [INSTR_W-1:0] instr);
    logic [DATA_W-1:0] b;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_XOR, OPC_PASS: b = rb_data;
      OPC_PAR, OPC_SPLIT:                  b = {13'd0, instr[IMM3_MSB:0]};
      OPC_MOD2:                            b = 16'd0;
      OPC_LDI:                             b = {11'd0, instr[IMM5_MSB:0]};
      default:                             b = 16'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the instruction handshake, ALU drive/sample, result handshake and debug read.
// The master modport is the controller's view; slave is the surrounding system.
interface alu_issue_ctrl_if;
  import alu_issue_ctrl_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [INSTR_W-1:0]  instr;
  logic [2:0]          alu_op;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_out;
  logic                alu_zero;
  logic                res_valid;
  logic                res_ready;
  logic [DATA_W-1:0]   result;
  logic                zero_flag;
  logic [REG_AW-1:0]   dbg_sel;
  logic [DATA_W-1:0]   dbg_data;

  modport master (
    input  in_valid, instr, alu_out, alu_zero, res_ready, dbg_sel,
    output in_ready, alu_op, alu_a, alu_b, res_valid, result, zero_flag, dbg_data
  );

  modport slave (
    output in_valid, instr, alu_out, alu_zero, res_ready, dbg_sel,
    input  in_ready, alu_op, alu_a, alu_b, res_valid, result, zero_flag, dbg_data
  );

endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// 4x16 register file: one synchronous write port, two combinational operand
// reads and one combinational debug read.
module alu_regfile
  import alu_issue_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  input  logic [REG_AW-1:0] i_dbg_sel,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_regs [NREG];

  // Storage with synchronous clear; reset wins over a coincident write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= 16'd0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_regs[i_raddr_a];
  assign o_rdata_b  = r_regs[i_raddr_b];
  assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 16-bit combinational ALU: accepts one instruction,
// holds ALU operands for ALU_LAT cycles, captures and writes back, then offers the result.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  alu_issue_ctrl_if.master  io_bus
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_accept;
  logic               w_capture;
  logic               w_release;
  logic [CNT_W-1:0]   r_cnt;
  logic [REG_AW-1:0]  r_ra;
  logic [2:0]         r_alu_op;
  logic [DATA_W-1:0]  r_alu_a;
  logic [DATA_W-1:0]  r_alu_b;
  logic [DATA_W-1:0]  r_result;
  logic               r_zero;
  logic               r_res_valid;

  logic [2:0]         w_opc;
  logic [REG_AW-1:0]  w_ra;
  logic [REG_AW-1:0]  w_rb;
  logic [DATA_W-1:0]  w_rdata_a;
  logic [DATA_W-1:0]  w_rdata_b;
  logic [DATA_W-1:0]  w_dbg_data;

  assign w_opc = io_bus.instr[OPC_MSB:OPC_LSB];
  assign w_ra  = io_bus.instr[RA_MSB:RA_LSB];
  assign w_rb  = io_bus.instr[RB_MSB:RB_LSB];

  alu_regfile u_regfile (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (w_capture),
    .i_waddr    (r_ra),
    .i_wdata    (io_bus.alu_out),
    .i_raddr_a  (w_ra),
    .i_raddr_b  (w_rb),
    .i_dbg_sel  (io_bus.dbg_sel),
    .o_rdata_a  (w_rdata_a),
    .o_rdata_b  (w_rdata_b),
    .o_dbg_data (w_dbg_data)
  );

  // Zero or out-of-range settle time cannot be represented by the wait counter.
  always_ff @(posedge i_clk) begin
    assert (ALU_LAT >= 1 && ALU_LAT <= 15)
      else $error("alu_issue_ctrl: ALU_LAT=%0d outside 1..15", ALU_LAT);
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the accept/capture/release strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (io_bus.res_ready) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand launch, settle countdown, result capture and result-valid flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= 4'd0;
      r_ra        <= 2'd0;
      r_alu_op    <= 3'd0;
      r_alu_a     <= 16'd0;
      r_alu_b     <= 16'd0;
      r_result    <= 16'd0;
      r_zero      <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_op <= map_alu_op(w_opc);
        r_alu_a  <= w_rdata_a;
        r_alu_b  <= sel_operand_b(w_opc, w_rdata_b, io_bus.instr);
        r_ra     <= w_ra;
        r_cnt    <= CNT_W'(ALU_LAT - 1);
      end else if (r_state == ST_EXEC && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_result    <= io_bus.alu_out;
        r_zero      <= io_bus.alu_zero;
        r_res_valid <= 1'b1;
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign io_bus.in_ready  = (r_state == ST_IDLE);
  assign io_bus.alu_op    = r_alu_op;
  assign io_bus.alu_a     = r_alu_a;
  assign io_bus.alu_b     = r_alu_b;
  assign io_bus.res_valid = r_res_valid;
  assign io_bus.result    = r_result;
  assign io_bus.zero_flag = r_zero;
  assign io_bus.dbg_data  = w_dbg_data;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench: two controllers (ALU_LAT=1 and 3) each driving a behavioural
// stand-in for the team ALU; expected values are hand-computed constants.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   lat;

  alu_issue_ctrl_if bus1 ();
  alu_issue_ctrl_if bus3 ();

  alu_issue_ctrl #(.ALU_LAT(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .io_bus(bus1));
  alu_issue_ctrl #(.ALU_LAT(3)) u_dut3 (.i_clk(clk), .i_rst(rst), .io_bus(bus3));

  always #5 clk = ~clk;

  // Team ALU stand-in: PAR = parity of A>>B, SPLIT = A>>B, MOD2 = A%2, PASS = B.
  function automatic logic [15:0] team_alu(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    logic [15:0] y;
    case (op)
      3'd0:    y = a + b;
      3'd1:    y = a - b;
      3'd2:    y = {15'd0, ^(a >> b)};
      3'd3:    y = a ^ b;
      3'd4:    y = a >> b;
      3'd5:    y = {15'd0, a[0]};
      3'd6:    y = b;
      default: y = 16'd0;
    endcase
    return y;
  endfunction

  assign bus1.alu_out  = team_alu(bus1.alu_op, bus1.alu_a, bus1.alu_b);
  assign bus1.alu_zero = (team_alu(bus1.alu_op, bus1.alu_a, bus1.alu_b) == 16'd0);
  assign bus3.alu_out  = team_alu(bus3.alu_op, bus3.alu_a, bus3.alu_b);
  assign bus3.alu_zero = (team_alu(bus3.alu_op, bus3.alu_a, bus3.alu_b) == 16'd0);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg1(input logic [1:0] sel, input logic [15:0] exp, input string tag);
    bus1.dbg_sel = sel;
    #1;
    chk(tag, bus1.dbg_data, exp);
  endtask

  // Issue one instruction on the LAT=1 unit and wait (bounded) for RES_VALID.
  task automatic run1(input logic [9:0] ins, output int l);
    bus1.in_valid = 1'b1;
    bus1.instr    = ins;
    step();
    bus1.in_valid = 1'b0;
    bus1.instr    = 10'h000;
    l = 1;
    while (bus1.res_valid !== 1'b1 && l < 40) begin
      step();
      l++;
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.instr     = 10'h000;
    bus1.res_ready = 1'b1;
    bus1.dbg_sel   = 2'd0;
    bus3.in_valid  = 1'b0;
    bus3.instr     = 10'h000;
    bus3.res_ready = 1'b1;
    bus3.dbg_sel   = 2'd0;
    step();
    step();
    rst = 1'b0;

    chk("rst_in_ready", {15'd0, bus1.in_ready}, 16'd1);
    chk("rst_res_valid", {15'd0, bus1.res_valid}, 16'd0);
    chk("rst_result", bus1.result, 16'd0);
    chk("rst_zero", {15'd0, bus1.zero_flag}, 16'd0);
    chk("rst_alu_op", {13'd0, bus1.alu_op}, 16'd0);
    chk("rst_alu_a", bus1.alu_a, 16'd0);
    chk("rst_alu_b", bus1.alu_b, 16'd0);
    dbg1(2'd3, 16'd0, "rst_r3");

    // LDI R0,5
    run1(10'h385, lat);
    chk("ldi_lat", 16'(lat), 16'd2);
    chk("ldi_result", bus1.result, 16'h0005);
    chk("ldi_zero", {15'd0, bus1.zero_flag}, 16'd0);
    chk("ldi_alu_op", {13'd0, bus1.alu_op}, 16'd6);
    chk("ldi_alu_b", bus1.alu_b, 16'd5);
    chk("ldi_in_ready", {15'd0, bus1.in_ready}, 16'd0);
    dbg1(2'd0, 16'd5, "ldi_r0");
    step();
    chk("hs_in_ready", {15'd0, bus1.in_ready}, 16'd1);
    chk("hs_res_valid", {15'd0, bus1.res_valid}, 16'd0);

    // LDI R1,3 ; ADD R0,R1 ; SUB R0,R0
    run1(10'h3A3, lat);
    chk("ldi_r1_result", bus1.result, 16'd3);
    step();
    run1(10'h008, lat);
    chk("add_result", bus1.result, 16'd8);
    chk("add_zero", {15'd0, bus1.zero_flag}, 16'd0);
    dbg1(2'd0, 16'd8, "add_r0");
    step();
    run1(10'h080, lat);
    chk("sub_result", bus1.result, 16'd0);
    chk("sub_zero", {15'd0, bus1.zero_flag}, 16'd1);
    dbg1(2'd0, 16'd0, "sub_r0");
    step();
    chk("post_hs_result", bus1.result, 16'd0);
    chk("post_hs_zero", {15'd0, bus1.zero_flag}, 16'd1);

    // PAR R1,IMM=0 with R1=3 ; LDI R1,5 ; MOD2 R1
    run1(10'h128, lat);
    chk("par_alu_op", {13'd0, bus1.alu_op}, 16'd2);
    chk("par_alu_a", bus1.alu_a, 16'd3);
    chk("par_alu_b", bus1.alu_b, 16'd0);
    chk("par_result", bus1.result, 16'd0);
    chk("par_zero", {15'd0, bus1.zero_flag}, 16'd1);
    step();
    run1(10'h3A5, lat);
    step();
    run1(10'h2A8, lat);
    chk("mod2_alu_b", bus1.alu_b, 16'd0);
    chk("mod2_result", bus1.result, 16'd1);
    chk("mod2_zero", {15'd0, bus1.zero_flag}, 16'd0);
    dbg1(2'd1, 16'd1, "mod2_r1");
    step();

    // Backpressure: LDI R2,9 held in RESP for 5 cycles with IN_VALID high
    bus1.res_ready = 1'b0;
    run1(10'h3C9, lat);
    chk("bp_lat", 16'(lat), 16'd2);
    bus1.in_valid = 1'b1;
    bus1.instr    = 10'h008;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", {15'd0, bus1.in_ready}, 16'd0);
      chk("bp_res_valid", {15'd0, bus1.res_valid}, 16'd1);
      chk("bp_result", bus1.result, 16'd9);
    end
    bus1.res_ready = 1'b1;
    step();
    chk("bp_rel_in_ready", {15'd0, bus1.in_ready}, 16'd1);
    chk("bp_rel_res_valid", {15'd0, bus1.res_valid}, 16'd0);
    step();
    bus1.in_valid = 1'b0;
    chk("bp_acc_in_ready", {15'd0, bus1.in_ready}, 16'd0);
    chk("bp_acc_alu_op", {13'd0, bus1.alu_op}, 16'd0);
    chk("bp_acc_alu_a", bus1.alu_a, 16'd0);
    chk("bp_acc_alu_b", bus1.alu_b, 16'd1);
    step();
    chk("bp_add_valid", {15'd0, bus1.res_valid}, 16'd1);
    chk("bp_add_result", bus1.result, 16'd1);
    dbg1(2'd0, 16'd1, "bp_add_r0");
    step();

    // XOR R2,R1 : 9 ^ 1
    run1(10'h1C8, lat);
    chk("xor_result", bus1.result, 16'd8);
    dbg1(2'd2, 16'd8, "xor_r2");
    step();

    // Reset during EXEC of ADD R0,R1
    bus1.in_valid = 1'b1;
    bus1.instr    = 10'h008;
    step();
    bus1.in_valid = 1'b0;
    chk("rx_exec_alu_a", bus1.alu_a, 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rx_in_ready", {15'd0, bus1.in_ready}, 16'd1);
    chk("rx_res_valid", {15'd0, bus1.res_valid}, 16'd0);
    chk("rx_result", bus1.result, 16'd0);
    chk("rx_alu_a", bus1.alu_a, 16'd0);
    dbg1(2'd0, 16'd0, "rx_r0");
    dbg1(2'd1, 16'd0, "rx_r1");
    dbg1(2'd2, 16'd0, "rx_r2");
    step();
    chk("rx_no_pulse", {15'd0, bus1.res_valid}, 16'd0);
    dbg1(2'd0, 16'd0, "rx_r0_late");

    // ALU_LAT=3 unit: LDI R3,7 operands held 3 cycles, RES_VALID at accept+4
    bus3.in_valid = 1'b1;
    bus3.instr    = 10'h3E7;
    step();
    bus3.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("l3_alu_op", {13'd0, bus3.alu_op}, 16'd6);
      chk("l3_alu_a", bus3.alu_a, 16'd0);
      chk("l3_alu_b", bus3.alu_b, 16'd7);
      chk("l3_res_valid_lo", {15'd0, bus3.res_valid}, 16'd0);
      step();
    end
    chk("l3_res_valid_hi", {15'd0, bus3.res_valid}, 16'd1);
    chk("l3_result", bus3.result, 16'd7);
    bus3.dbg_sel = 2'd3;
    #1;
    chk("l3_r3", bus3.dbg_data, 16'd7);
    step();
    // SPLIT R3, IMM=1 : 7 >> 1
    bus3.in_valid = 1'b1;
    bus3.instr    = 10'h261;
    step();
    bus3.in_valid = 1'b0;
    repeat (3) step();
    chk("l3_split_valid", {15'd0, bus3.res_valid}, 16'd1);
    chk("l3_split_result", bus3.result, 16'd3);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencing master for the team's combinational 16-bit ALU. It accepts 10-bit instructions over a valid/ready handshake and reads operands from an internal 4x16 register file. It drives the ALU OP/A/B inputs, waits a fixed settle time, captures the ALU result and zero flag, writes the result back, and presents it on a valid/ready result port. It sits between instruction fetch and the ALU and is the initiator side of the ALU interface.

Parameters:
ALU_LAT, 1, cycles the ALU operands are held before OUT/ZERO are sampled; legal range 1..15, 0 is illegal and asserted in simulation.
NREG, 4, register file depth; fixed by the 2-bit register fields.

Ports:
CLK  in  1  sole clock, rising edge
RST  in  1  synchronous, active-high reset
IN_VALID  in  1  instruction valid
IN_READY  out  1  controller can accept an instruction
INSTR  in  10  [9:7] OPC, [6:5] RA (dest and src A), [4:3] RB, [2:0] IMM3
ALU_OP  out  3  to ALU OP
ALU_A  out  16  to ALU INPUTA
ALU_B  out  16  to ALU INPUTB
ALU_OUT  in  16  from ALU OUT
ALU_ZERO  in  1  from ALU ZERO
RES_VALID  out  1  result valid
RES_READY  in  1  result consumer ready
RESULT  out  16  captured ALU result
ZERO_FLAG  out  1  captured ALU zero
DBG_SEL  in  2  register file debug read select
DBG_DATA  out  16  R[DBG_SEL], combinational read

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- Reset values: R0..R3=0, ALU_OP/ALU_A/ALU_B=0, RESULT=0, ZERO_FLAG=0, RES_VALID=0, wait counter=0.
- IN_READY = (state==IDLE). It is combinational from state, never from IN_VALID.
- IDLE, on IN_VALID & IN_READY at an edge:
  - Register operands. ALU_OP=OPC except OPC 7 drives ALU_OP=6 (PASS).
  - ALU_A=R[RA].
  - ALU_B by OPC: 0,1,3,6 -> R[RB]; 2,4 -> zero-extended IMM3 (selector); 5 -> 0; 7 -> zero-extended INSTR[4:0] (load immediate).
  - Load counter=ALU_LAT-1 and go to EXEC.
- EXEC: ALU_OP/A/B are held stable. The counter decrements each cycle.
  - At the edge where counter==0: RESULT<=ALU_OUT, ZERO_FLAG<=ALU_ZERO, R[RA]<=ALU_OUT (every OPC writes RA), then go to RESP.
- RESP: RES_VALID=1. RESULT and ZERO_FLAG are held.
  - On RES_READY at an edge: go to IDLE and drop RES_VALID the next cycle.
  - RES_READY low stalls indefinitely. No new instruction is accepted while stalled.
- Latency with ALU_LAT=1: accept at edge 0, operands valid in cycle 1, RES_VALID high in cycle 2. In general RES_VALID rises ALU_LAT+1 cycles after accept.
- Peak throughput is one instruction per ALU_LAT+2 cycles, with one IDLE cycle minimum between instructions.
- Instructions are strictly serial, so there are no register hazards. RA==RB is legal and reads the old value.
- ALU_OP/A/B keep their last values outside EXEC; the ALU output is ignored outside the capture edge.
- RESULT/ZERO_FLAG stay valid after the handshake until the next capture.
- IN_VALID in EXEC/RESP is ignored. INSTR need only be stable at the accept edge.
- DBG_DATA reflects a write-back from the cycle after the capture edge.
- RST in any state: return to IDLE next edge with all reset values. An in-flight write-back is discarded, and no RES_VALID pulse is produced.
- Arithmetic is performed by the ALU, modulo 2^16. The controller does no width extension beyond the zero-extension rules above.

Decomposition:
- Shared package: ALU opcode constants (ADD=0, SUB=1, PAR=2, XOR=3, SPLIT=4, MOD2=5, PASS=6), controller opcode LDI=7, INSTR field bit positions, FSM state encoding.
- One natural sub-module: alu_regfile (4x16, one synchronous write port, two combinational read ports plus a debug read). The FSM and operand muxing stay in the top.

Test Plan:
(The bench instantiates the team ALU, ALU_LAT=1, RES_READY=1 unless stated.)
1. Reset, then INSTR=0x385 (LDI R0,5) -> RES_VALID exactly 2 cycles after accept; RESULT=0x0005, ZERO_FLAG=0, DBG_SEL=0 reads 5.
2. 0x3A3 (LDI R1,3), then 0x008 (ADD R0,R1) -> RESULT=8, R0=8. Then 0x080 (SUB R0,R0) -> RESULT=0, ZERO_FLAG=1, R0=0.
3. R1=3, INSTR=0x128 (PAR R1, IMM=0) -> ALU_B=0, RESULT=0, ZERO_FLAG=1. R1=5 via LDI, then INSTR=0x2A8 (MOD2 R1) -> RESULT=1.
4. Backpressure: hold RES_READY=0 for 5 cycles during RESP while IN_VALID=1 -> IN_READY=0, RES_VALID=1, RESULT stable. Release -> IDLE next cycle, then accept.
5. ALU_LAT=3 build: ALU_OP/A/B stable for 3 cycles; RES_VALID at accept+4.
6. Assert RST for 1 cycle during EXEC of ADD -> no RES_VALID, R0..R3=0, IN_READY=1 the cycle after reset deasserts.
